// File: rtl/output_port_interface_pkg.sv
// Shared constants for the byte output port: bus window, status bit layout
// and the handshake state encoding.
package output_port_interface_pkg;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0ABC;
    localparam logic [15:0] DATA_OFFSET       = 16'd1;

    localparam int TBE_BIT = 5;
    localparam int OVR_BIT = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FULL     = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_RFD = 2'd3
    } state_t;

    function automatic logic [7:0] status_byte(input logic tbe, input logic ovr);
        logic [7:0] s;
        s          = 8'h00;
        s[TBE_BIT] = tbe;
        s[OVR_BIT] = ovr;
        return s;
    endfunction

endpackage

// File: rtl/output_port_interface.sv
// Bus-side output port: status/data registers in a 2-byte I/O window and a
// dav_/rfd 4-phase handshake toward the downstream consumer.
module output_port_interface
    import output_port_interface_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        ior_,
    input  logic        iow_,
    inout  wire  [7:0]  data,
    output logic [7:0]  byte_out,
    output logic        dav_,
    input  logic        rfd
);

    state_t     state_q, state_d;
    logic [7:0] buf_q, buf_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       dav_n_q, dav_n_d;
    logic       ovr_q, ovr_d;
    logic       ior_q, iow_q, rd_sel_q;

    logic [15:0] data_addr;
    logic        status_sel, data_sel;
    logic        tbe, write_edge, read_done;

    assign data_addr  = BASE_ADDR + DATA_OFFSET;
    assign status_sel = (addr == BASE_ADDR);
    assign data_sel   = (addr == data_addr);

    // The buffer is free only while no byte is anywhere in the handshake.
    assign tbe        = (state_q == IDLE);

    assign write_edge = !iow_ && iow_q && data_sel;
    assign read_done  = ior_ && !ior_q && rd_sel_q;

    assign data     = (!ior_ && status_sel) ? status_byte(tbe, ovr_q) : 8'hzz;
    assign byte_out = byte_out_q;
    assign dav_     = dav_n_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        byte_out_d = byte_out_q;
        dav_n_d    = dav_n_q;
        ovr_d      = ovr_q;

        if (read_done)
            ovr_d = 1'b0;

        // A fresh overrun wins over a read-clear landing on the same edge.
        if (write_edge) begin
            if (tbe) begin
                buf_d   = data;
                state_d = FULL;
            end else begin
                ovr_d   = 1'b1;
            end
        end

        case (state_q)
            IDLE: ;
            FULL: begin
                if (rfd) begin
                    byte_out_d = buf_q;
                    dav_n_d    = 1'b0;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!rfd) begin
                    dav_n_d = 1'b1;
                    state_d = WAIT_RFD;
                end
            end
            WAIT_RFD: begin
                if (rfd)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            buf_q      <= 8'h00;
            byte_out_q <= 8'h00;
            dav_n_q    <= 1'b1;
            ovr_q      <= 1'b0;
            ior_q      <= 1'b1;
            iow_q      <= 1'b1;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            byte_out_q <= byte_out_d;
            dav_n_q    <= dav_n_d;
            ovr_q      <= ovr_d;
            ior_q      <= ior_;
            iow_q      <= iow_;
            rd_sel_q   <= status_sel;
        end
    end

endmodule

// File: tb/tb_output_port_interface.sv
// Directed scenarios followed by randomized bus/consumer traffic checked
// against a behavioural model of the output port.
module tb_output_port_interface;

    localparam logic [15:0] STAT = 16'h0ABC;
    localparam logic [15:0] DREG = 16'h0ABD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr  = 16'h0000;
    logic        ior_  = 1'b1;
    logic        iow_  = 1'b1;
    logic        rfd   = 1'b1;
    wire  [7:0]  data;
    logic [7:0]  byte_out;
    logic        dav_;

    logic        drv_en  = 1'b0;
    logic [7:0]  drv_val = 8'h00;
    assign data = drv_en ? drv_val : 8'hzz;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    output_port_interface dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .ior_     (ior_),
        .iow_     (iow_),
        .data     (data),
        .byte_out (byte_out),
        .dav_     (dav_),
        .rfd      (rfd)
    );

    // Behavioural model: a byte is held from acceptance until the consumer
    // completes the full 4-phase handshake.
    logic       m_have, m_dav_low, m_released, m_ovr;
    logic [7:0] m_buf, m_out;
    logic       m_iow_prev, m_ior_prev, m_rd_hit;
    logic       m_we, m_rc;
    int         act;
    logic       last_read;

    function automatic logic [7:0] m_status();
        return {2'b00, !m_have, 3'b000, m_ovr, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Status read with no posedge inside the strobe, so OVR is untouched.
    task automatic peek(input string tag, input logic [7:0] exp);
        addr   = STAT;
        drv_en = 1'b0;
        ior_   = 1'b0;
        #1;
        check(tag, data, exp);
        ior_   = 1'b1;
    endtask

    // The bench parks 8'h44 on the bus; an extra DUT driver would corrupt it.
    task automatic hiz(input string tag, input logic [15:0] a);
        addr    = a;
        drv_val = 8'h44;
        drv_en  = 1'b1;
        ior_    = 1'b0;
        #1;
        check(tag, data, 8'h44);
        ior_    = 1'b1;
        drv_en  = 1'b0;
    endtask

    // Full read bus cycle: strobe spans one edge, then the release edge.
    task automatic read_clear(input string tag, input logic [7:0] exp);
        addr   = STAT;
        drv_en = 1'b0;
        ior_   = 1'b0;
        #1;
        check(tag, data, exp);
        step();
        ior_   = 1'b1;
        step();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int n);
        addr    = a;
        drv_val = d;
        drv_en  = 1'b1;
        iow_    = 1'b0;
        repeat (n) step();
        iow_    = 1'b1;
        drv_en  = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        check("rst_dav_in_reset", dav_, 1'b1);
        check("rst_byte_out_in_reset", byte_out, 8'h00);
        reset = 1'b0;
        step();
        peek("rst_status", 8'h20);
        hiz("rst_hiz_data_reg", DREG);
        check("rst_dav", dav_, 1'b1);
        check("rst_byte_out", byte_out, 8'h00);

        // Single byte through an immediately responsive consumer
        rfd     = 1'b1;
        addr    = DREG;
        drv_val = 8'h5A;
        drv_en  = 1'b1;
        iow_    = 1'b0;
        step();
        iow_    = 1'b1;
        drv_en  = 1'b0;
        peek("wr_tbe_same_edge", 8'h00);
        check("wr_dav_not_yet", dav_, 1'b1);
        step();
        check("wr_dav_fall", dav_, 1'b0);
        check("wr_byte_out", byte_out, 8'h5A);
        rfd = 1'b0;
        step();
        check("ack_dav_rise", dav_, 1'b1);
        check("ack_byte_hold", byte_out, 8'h5A);
        peek("wait_rfd_status", 8'h00);
        rfd = 1'b1;
        step();
        peek("ready_again", 8'h20);

        // Overrun with a stalled consumer
        rfd = 1'b0;
        wr(DREG, 8'h11, 1);
        wr(DREG, 8'h22, 1);
        peek("ovr_status", 8'h02);
        check("ovr_dav_hold", dav_, 1'b1);
        rfd = 1'b1;
        step();
        check("ovr_dav_fall", dav_, 1'b0);
        check("ovr_first_kept", byte_out, 8'h11);
        rfd = 1'b0;
        step();
        rfd = 1'b1;
        step();
        read_clear("ovr_read", 8'h22);
        peek("ovr_cleared", 8'h20);

        // Long write strobe counts once
        rfd = 1'b0;
        wr(DREG, 8'h33, 4);
        peek("long_strobe_status", 8'h00);
        rfd = 1'b1;
        step();
        check("long_strobe_dav", dav_, 1'b0);
        check("long_strobe_byte", byte_out, 8'h33);
        rfd = 1'b0;
        step();
        rfd = 1'b1;
        step();
        peek("long_strobe_done", 8'h20);

        // Writes outside the data register are ignored
        wr(16'h0ABE, 8'h99, 1);
        wr(STAT, 8'h98, 1);
        peek("bad_addr_status", 8'h20);
        check("bad_addr_dav", dav_, 1'b1);
        step();
        check("bad_addr_dav_later", dav_, 1'b1);
        check("bad_addr_byte", byte_out, 8'h33);

        // Write on the edge that returns WAIT_RFD to IDLE is an overrun
        wr(DREG, 8'h66, 1);
        check("simul_dav_low", dav_, 1'b0);
        check("simul_byte", byte_out, 8'h66);
        rfd = 1'b0;
        step();
        rfd     = 1'b1;
        addr    = DREG;
        drv_val = 8'h67;
        drv_en  = 1'b1;
        iow_    = 1'b0;
        step();
        iow_    = 1'b1;
        drv_en  = 1'b0;
        peek("simul_status", 8'h22);
        check("simul_dav", dav_, 1'b1);
        step();
        check("simul_dropped", dav_, 1'b1);
        peek("simul_still_empty", 8'h22);
        read_clear("simul_read", 8'h22);

        // Reset in the middle of a handshake
        wr(DREG, 8'h77, 1);
        check("pre_reset_dav", dav_, 1'b0);
        reset = 1'b1;
        step();
        check("reset_dav", dav_, 1'b1);
        check("reset_byte_out", byte_out, 8'h00);
        peek("reset_status", 8'h20);
        reset = 1'b0;
        step();
        check("post_reset_dav", dav_, 1'b1);

        // Randomized traffic against the model
        reset = 1'b1;
        step();
        reset      = 1'b0;
        m_have     = 1'b0;
        m_dav_low  = 1'b0;
        m_released = 1'b0;
        m_ovr      = 1'b0;
        m_buf      = 8'h00;
        m_out      = 8'h00;
        m_iow_prev = 1'b1;
        m_ior_prev = 1'b1;
        m_rd_hit   = 1'b0;
        last_read  = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            check("rnd_dav", dav_, m_dav_low ? 1'b0 : 1'b1);
            check("rnd_byte_out", byte_out, m_out);

            act = int'($urandom_range(0, 9));
            // Keep a write edge off the edge that ends a status read.
            if (last_read && act < 4)
                act = 9;
            rfd    = ($urandom_range(0, 3) != 0);
            ior_   = 1'b1;
            iow_   = 1'b1;
            drv_en = 1'b0;
            if (act < 4) begin
                addr    = ($urandom_range(0, 4) == 0) ? 16'h0ABE : DREG;
                drv_val = 8'($urandom);
                drv_en  = 1'b1;
                iow_    = 1'b0;
            end else if (act < 6) begin
                addr = ($urandom_range(0, 3) == 0) ? DREG : STAT;
                ior_ = 1'b0;
                if (addr == DREG) begin
                    drv_val = 8'h44;
                    drv_en  = 1'b1;
                end
            end else begin
                addr = 16'($urandom);
            end
            #1;
            if (!ior_) begin
                if (addr == STAT)
                    check("rnd_status", data, m_status());
                else
                    check("rnd_hiz", data, 8'h44);
            end

            m_we = !iow_ && m_iow_prev && (addr == DREG);
            m_rc = ior_ && !m_ior_prev && m_rd_hit;
            if (m_we && m_have)
                m_ovr = 1'b1;
            else if (m_rc)
                m_ovr = 1'b0;
            if (m_have) begin
                if (m_released) begin
                    if (rfd) begin
                        m_released = 1'b0;
                        m_have     = 1'b0;
                    end
                end else if (m_dav_low) begin
                    if (!rfd) begin
                        m_dav_low  = 1'b0;
                        m_released = 1'b1;
                    end
                end else if (rfd) begin
                    m_out     = m_buf;
                    m_dav_low = 1'b1;
                end
            end else if (m_we) begin
                m_buf  = drv_val;
                m_have = 1'b1;
            end
            m_iow_prev = iow_;
            m_ior_prev = ior_;
            m_rd_hit   = !ior_ && (addr == STAT);
            last_read  = !ior_;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_port_interface.md
# output_port_interface

Bus-side output interface answering the byte-emitting controller: decodes a 2-byte I/O window on the 16-bit address bus, exposes a status register whose bit 5 means "ready to accept", latches the byte written to the data register, and delivers it to a downstream consumer through a dav_/rfd 4-phase handshake. Sits between the system I/O bus (addr, data, ior_, iow_) and the consumer device.

## Interface
- BASE_ADDR, 16'h0ABC, address of the status register (read-only); data register (write-only) is BASE_ADDR+1.
- clock  input  1  system clock, all state changes on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clock.
- addr  input  16  bus address, driven by the controller.
- ior_  input  1  read strobe, active low.
- iow_  input  1  write strobe, active low.
- data  inout  8  bus data; driven only during a status read, else high-Z.
- byte_out  output  8  byte offered to the consumer.
- dav_  output  1  data-available to consumer, active low.
- rfd  input  1  consumer ready-for-data, active high.

## Operation
- Status byte: bit 5 TBE (1 = buffer empty), bit 1 OVR (overrun), all other bits 0.
- Read: while ior_==0 and addr==BASE_ADDR, data = status byte (combinational from registers); otherwise data = 8'hZZ. Reads of BASE_ADDR+1 leave data high-Z.
- Read-clear: on a posedge where ior_==1 and the previously sampled ior_ was 0 with addr==BASE_ADDR, OVR <= 0.
- Write accept: on a posedge where iow_==0, previously sampled iow_==1 (edge-qualified, one write per strobe regardless of strobe length) and addr==BASE_ADDR+1.
  - If TBE==1: BUF <= data, TBE <= 0, state -> FULL.
  - If TBE==0: byte dropped, OVR <= 1, state unchanged.
- State machine (2-bit, states IDLE, FULL, WAIT_ACK, WAIT_RFD):
  - IDLE: TBE=1, dav_=1. Accepted write -> FULL.
  - FULL: if rfd==1: byte_out <= BUF, dav_ <= 0 -> WAIT_ACK; else stay.
  - WAIT_ACK: if rfd==0: dav_ <= 1 -> WAIT_RFD; else stay.
  - WAIT_RFD: if rfd==1: TBE <= 1 -> IDLE; else stay.
- byte_out held stable from the dav_ falling edge until the next load; never changes while dav_==0.

## Timing
- Reset values: data high-Z, byte_out=8'h00, dav_=1, TBE=1, OVR=0, BUF=8'h00, state IDLE, strobe history registers=1.
- Write at posedge k -> TBE reads 0 from k; dav_ falls at k+1 earliest (rfd already 1).
- Minimum write-to-ready round trip: 3 edges after acceptance with an immediately responsive consumer (FULL, WAIT_ACK, WAIT_RFD each one edge).
- Status read latency: zero cycles (combinational); bit 5 reflects registered TBE.
- Simultaneous events: write at the same edge WAIT_RFD returns to IDLE -> treated as overrun (TBE still 0 at that edge); byte dropped, OVR=1.
- Read and write strobes both low: write handled, read drives data only if addr==BASE_ADDR (disjoint addresses, no conflict).
- Reset mid-handshake: all registers to reset values at that edge; dav_ returns high, pending byte discarded.

## Structure
- Shared package: BASE_ADDR default, data-register offset (1), status bit indices TBE_BIT=5 and OVR_BIT=1, state encoding constants IDLE/FULL/WAIT_ACK/WAIT_RFD.
- Single module; the address decode and strobe edge detection are a few lines and do not warrant a sub-module.

## Test plan
- Reset, then read addr 16'h0ABC with ior_ low -> data=8'h20; addr 16'h0ABD read -> data high-Z; dav_=1, byte_out=8'h00.
- Write 8'h5A to 16'h0ABD (iow_ low one cycle), rfd=1 -> TBE=0 same edge, byte_out=8'h5A and dav_=0 next edge; rfd drops -> dav_=1; rfd rises -> status reads 8'h20 again.
- Hold rfd=0, write 8'h11 then 8'h22 -> status reads 8'h02 (TBE=0, OVR=1); consumer later receives 8'h11 only; read of status clears OVR -> subsequent read 8'h00 or 8'h20.
- iow_ held low 4 cycles at 16'h0ABD with data 8'h33 -> exactly one write, OVR stays 0.
- Write to 16'h0ABE or 16'h0ABC -> ignored, TBE stays 1, dav_ stays 1.
- Assert reset while dav_=0 -> next edge dav_=1, status 8'h20, byte_out=8'h00.
